imm_gen_pipe: RTL and testbench

Parametrised, registered immediate generator for the decode stage of the pipelined core. It decodes the format of a 32-bit RISC-V instruction (I, S, B, U, J, plus shift-immediate) from the opcode and emits the sign-extended immediate at width XLEN. A two-entry skid buffer gives it valid/ready handshakes on both sides. It sits between fetch/IF-ID and the ID-EX register, and accepts one instruction per cycle at full throughput.

---
 rtl/imm_pkg.sv | 28 ++
 rtl/imm_gen_pipe_if.sv | 27 ++
 rtl/imm_decode.sv | 87 ++++++++
 rtl/imm_gen_pipe.sv | 82 ++++++++
 tb/tb_imm_gen_pipe.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/imm_pkg.sv
// Shared format codes, opcodes and shift funct3 values for the immediate generator.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SH   = 3'd6
  } imm_fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Valid/ready instruction-in / immediate-out bundle for imm_gen_pipe.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN = 64
);
  import imm_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instruction;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm_data;
  imm_fmt_e        imm_fmt;
  logic            imm_illegal;

  // Block side
  modport slave (
    input  in_valid, instruction, out_ready,
    output in_ready, out_valid, imm_data, imm_fmt, imm_illegal
  );

  // Producer/consumer side
  modport master (
    output in_valid, instruction, out_ready,
    input  in_ready, out_valid, imm_data, imm_fmt, imm_illegal
  );
endinterface

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate format decode and sign extension to XLEN.
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0]     instruction,
  input  logic            en_rv64i,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);

  logic [6:0]  op;
  logic [2:0]  f3;
  logic        is_shift;
  logic [31:0] imm32;

  assign op       = instruction[6:0];
  assign f3       = instruction[14:12];
  assign is_shift = (f3 == F3_SLLI) || (f3 == F3_SRXI);

  // Build a 32-bit immediate first; every format is either signed or a small
  // positive shamt, so one sign extension to XLEN covers all cases.
  assign imm = XLEN'($signed(imm32));

  // Select format and assemble the 32-bit immediate from the opcode
  always_comb begin
    imm32   = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    unique case (op)
      OP_LOAD, OP_JALR, OP_SYSTEM: begin
        fmt   = FMT_I;
        imm32 = {{20{instruction[31]}}, instruction[31:20]};
      end
      OP_IMM: begin
        if (is_shift) begin
          fmt = FMT_SH;
          if (XLEN == 64)
            imm32 = {26'b0, instruction[25:20]};
          else if (instruction[25])
            illegal = 1'b1;
          else
            imm32 = {27'b0, instruction[24:20]};
        end else begin
          fmt   = FMT_I;
          imm32 = {{20{instruction[31]}}, instruction[31:20]};
        end
      end
      OP_IMM32: begin
        if (!en_rv64i) begin
          illegal = 1'b1;
        end else if (is_shift) begin
          fmt = FMT_SH;
          if (instruction[25])
            illegal = 1'b1;
          else
            imm32 = {27'b0, instruction[24:20]};
        end else begin
          fmt   = FMT_I;
          imm32 = {{20{instruction[31]}}, instruction[31:20]};
        end
      end
      OP_STORE: begin
        fmt   = FMT_S;
        imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      end
      OP_BRANCH: begin
        fmt   = FMT_B;
        imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                 instruction[30:25], instruction[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt   = FMT_U;
        imm32 = {instruction[31:12], 12'b0};
      end
      OP_JAL: begin
        fmt   = FMT_J;
        imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                 instruction[20], instruction[30:21], 1'b0};
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a two-entry skid buffer (M output, K skid).
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter bit          EN_RV64I = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  imm_gen_pipe_if.slave bus
);

  if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  localparam bit EN64 = EN_RV64I && (XLEN == 64);

  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_ill;

  logic            m_valid, k_valid;
  logic [XLEN-1:0] m_imm, k_imm;
  imm_fmt_e        m_fmt, k_fmt;
  logic            m_ill, k_ill;

  logic accept, emit;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instruction (bus.instruction),
    .en_rv64i    (EN64),
    .imm         (dec_imm),
    .fmt         (dec_fmt),
    .illegal     (dec_ill)
  );

  assign bus.in_ready    = ~k_valid;
  assign bus.out_valid   = m_valid;
  assign bus.imm_data    = m_imm;
  assign bus.imm_fmt     = m_fmt;
  assign bus.imm_illegal = m_ill;

  assign accept = bus.in_valid & ~k_valid;
  assign emit   = m_valid & bus.out_ready;

  // Skid-buffer state: M refills from K first so ordering stays FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      k_valid <= 1'b0;
      m_imm   <= '0;
      m_fmt   <= FMT_NONE;
      m_ill   <= 1'b0;
    end else if (flush) begin
      m_valid <= 1'b0;
      k_valid <= 1'b0;
    end else if (!m_valid || emit) begin
      if (k_valid) begin
        m_valid <= 1'b1;
        m_imm   <= k_imm;
        m_fmt   <= k_fmt;
        m_ill   <= k_ill;
        k_valid <= 1'b0;
      end else if (accept) begin
        m_valid <= 1'b1;
        m_imm   <= dec_imm;
        m_fmt   <= dec_fmt;
        m_ill   <= dec_ill;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (accept) begin
      k_valid <= 1'b1;
      k_imm   <= dec_imm;
      k_fmt   <= dec_fmt;
      k_ill   <= dec_ill;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=64 and XLEN=32 instances share stimulus.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        in_valid, out_ready;
  logic [31:0] instruction;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(64)) b64 ();
  imm_gen_pipe_if #(.XLEN(32)) b32 ();

  assign b64.in_valid    = in_valid;
  assign b64.instruction = instruction;
  assign b64.out_ready   = out_ready;
  assign b32.in_valid    = in_valid;
  assign b32.instruction = instruction;
  assign b32.out_ready   = out_ready;

  imm_gen_pipe #(.XLEN(64), .EN_RV64I(1'b1)) dut64 (
    .clk (clk), .reset (reset), .flush (flush), .bus (b64.slave)
  );
  imm_gen_pipe #(.XLEN(32), .EN_RV64I(1'b1)) dut32 (
    .clk (clk), .reset (reset), .flush (flush), .bus (b32.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp64(input string tag, input logic [63:0] imm, input imm_fmt_e fmt,
                       input logic ill);
    check({tag, ".valid"}, 64'(b64.out_valid), 64'd1);
    check({tag, ".imm"},   b64.imm_data, imm);
    check({tag, ".fmt"},   64'(b64.imm_fmt), 64'(fmt));
    check({tag, ".ill"},   64'(b64.imm_illegal), 64'(ill));
  endtask

  task automatic exp_reset(input string tag);
    check({tag, ".out_valid"}, 64'(b64.out_valid), 64'd0);
    check({tag, ".in_ready"},  64'(b64.in_ready), 64'd1);
    check({tag, ".imm"},       b64.imm_data, 64'd0);
    check({tag, ".fmt"},       64'(b64.imm_fmt), 64'(FMT_NONE));
    check({tag, ".ill"},       64'(b64.imm_illegal), 64'd0);
    check({tag, ".imm32"},     64'(b32.imm_data), 64'd0);
  endtask

  task automatic drive(input logic [31:0] w);
    instruction = w;
    in_valid    = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instruction = '0;
    tick();
    exp_reset("rst");
    reset = 1'b0;

    // Streaming decode with out_ready held high
    drive(32'hFFF00093);
    exp64("addi", 64'hFFFF_FFFF_FFFF_FFFF, FMT_I, 1'b0);
    check("addi.imm32", 64'(b32.imm_data), 64'hFFFF_FFFF);
    drive(32'h123450B7);
    exp64("lui", 64'h0000_0000_1234_5000, FMT_U, 1'b0);
    drive(32'h800000B7);
    exp64("lui_neg", 64'hFFFF_FFFF_8000_0000, FMT_U, 1'b0);
    check("lui_neg.imm32", 64'(b32.imm_data), 64'h8000_0000);
    drive(32'hFE000EE3);
    exp64("beq", 64'hFFFF_FFFF_FFFF_FFFC, FMT_B, 1'b0);
    drive(32'h001000EF);
    exp64("jal", 64'h800, FMT_J, 1'b0);
    drive(32'hFE112E23);
    exp64("sw", 64'hFFFF_FFFF_FFFF_FFFC, FMT_S, 1'b0);
    drive(32'h03F09093);
    exp64("slli63", 64'h3F, FMT_SH, 1'b0);
    check("slli63.ill32", 64'(b32.imm_illegal), 64'd1);
    check("slli63.imm32", 64'(b32.imm_data), 64'd0);
    check("slli63.fmt32", 64'(b32.imm_fmt), 64'(FMT_SH));
    drive(32'h0000007F);
    exp64("badop", 64'd0, FMT_NONE, 1'b1);
    drive(32'h0010809B);
    exp64("addiw", 64'd1, FMT_I, 1'b0);
    check("addiw.fmt32", 64'(b32.imm_fmt), 64'(FMT_NONE));
    check("addiw.ill32", 64'(b32.imm_illegal), 64'd1);
    drive(32'h0250909B);
    exp64("slliw_bad", 64'd0, FMT_SH, 1'b1);
    in_valid = 1'b0;
    tick();
    check("idle.out_valid", 64'(b64.out_valid), 64'd0);

    // Backpressure: A into M, B into K, C held off
    out_ready = 1'b0;
    drive(32'hFFF00093);
    exp64("bp.A", 64'hFFFF_FFFF_FFFF_FFFF, FMT_I, 1'b0);
    check("bp.A.in_ready", 64'(b64.in_ready), 64'd1);
    drive(32'h123450B7);
    check("bp.B.in_ready", 64'(b64.in_ready), 64'd0);
    exp64("bp.hold1", 64'hFFFF_FFFF_FFFF_FFFF, FMT_I, 1'b0);
    drive(32'h001000EF);
    exp64("bp.hold2", 64'hFFFF_FFFF_FFFF_FFFF, FMT_I, 1'b0);
    check("bp.C.in_ready", 64'(b64.in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    exp64("bp.outB", 64'h0000_0000_1234_5000, FMT_U, 1'b0);
    check("bp.release.in_ready", 64'(b64.in_ready), 64'd1);
    tick();
    exp64("bp.outC", 64'h800, FMT_J, 1'b0);
    in_valid = 1'b0;
    tick();
    check("bp.drained", 64'(b64.out_valid), 64'd0);

    // Flush with an accept in the same cycle discards the input
    flush = 1'b1;
    drive(32'hFE112E23);
    check("fl.accept.out_valid", 64'(b64.out_valid), 64'd0);

    // Flush with both entries full
    flush = 1'b0;
    out_ready = 1'b0;
    drive(32'hFE112E23);
    drive(32'h0000007F);
    check("fl.full.in_ready", 64'(b64.in_ready), 64'd0);
    flush = 1'b1;
    instruction = 32'h123450B7;
    tick();
    flush = 1'b0;
    check("fl.out_valid", 64'(b64.out_valid), 64'd0);
    check("fl.in_ready", 64'(b64.in_ready), 64'd1);
    out_ready = 1'b1;
    drive(32'h800000B7);
    exp64("fl.next", 64'hFFFF_FFFF_8000_0000, FMT_U, 1'b0);
    in_valid = 1'b0;
    tick();
    check("fl.no_dup", 64'(b64.out_valid), 64'd0);

    // Reset while stalled with two entries held
    out_ready = 1'b0;
    drive(32'hFFF00093);
    drive(32'h001000EF);
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_reset("rst_stall");
    out_ready = 1'b1;
    tick();
    check("rst_stall.no_stale", 64'(b64.out_valid), 64'd0);
    check("rst_stall.in_ready", 64'(b64.in_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
